// File: rtl/alu_op_decoder.sv
// alu_op_decoder: RV32I ALU-op decoder feeding a 2-entry skid FIFO.
// Instructions are decoded on entry; the head record drives out_*.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake (in_instr)
//   out_valid/out_ready      record handshake toward the ALU stage
//   out_alu_op               5-bit ALU op code
//   out_rs1/out_rs2/out_rd   register indices
//   out_imm, out_b_is_imm    operand-B immediate and its select
//   out_illegal              only with ALU_DEC_ILLEGAL_EN defined
// Build option ALU_DEC_ILLEGAL_EN: illegal instructions become records
// flagged out_illegal instead of being silently dropped.
module alu_op_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_alu_op,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic        out_b_is_imm
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic        out_illegal
`endif
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLT  = 5'b01100;
    localparam logic [4:0] OP_SLTU = 5'b01110;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01011;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        b_is_imm;
`ifdef ALU_DEC_ILLEGAL_EN
        logic        illegal;
`endif
    } rec_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_zero;
    logic       f7_alt;
    logic       is_shift;
    logic       dec_legal;
    logic       keep;
    rec_t       dec;

    assign opc     = in_instr[6:0];
    assign f3      = in_instr[14:12];
    assign f7      = in_instr[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        case (opc)
            OPC_OP: begin
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
                dec.rd  = in_instr[11:7];
                // The alternate funct7 only selects SUB and SRA.
                dec_legal = f7_zero ||
                            (f7_alt && (f3 == 3'b000 || f3 == 3'b101));
                if (f7_alt)
                    dec.alu_op = (f3 == 3'b000) ? OP_SUB : OP_SRA;
                else
                    dec.alu_op = base_op(f3);
            end
            OPC_OP_IMM: begin
                dec.rs1      = in_instr[19:15];
                dec.rd       = in_instr[11:7];
                dec.b_is_imm = 1'b1;
                // Only shifts constrain bits [31:25]; they carry shamt.
                dec_legal = !is_shift || f7_zero ||
                            (f7_alt && f3 == 3'b101);
                if (f3 == 3'b101 && f7_alt)
                    dec.alu_op = OP_SRA;
                else
                    dec.alu_op = base_op(f3);
                if (is_shift)
                    dec.imm = {27'b0, in_instr[24:20]};
                else
                    dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_LUI: begin
                dec_legal    = 1'b1;
                dec.alu_op   = OP_ADD;
                dec.rd       = in_instr[11:7];
                dec.imm      = {in_instr[31:12], 12'b0};
                dec.b_is_imm = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec = '0;
`ifdef ALU_DEC_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
        end
    end

`ifdef ALU_DEC_ILLEGAL_EN
    assign keep = 1'b1;
`else
    assign keep = dec_legal;
`endif

    occ_t occ_q, occ_d;
    rec_t ent0_q, ent0_d;
    rec_t ent1_q, ent1_d;
    logic accept;
    logic push;
    logic pop;

    assign in_ready  = !rst && (occ_q != TWO);
    assign out_valid = !rst && (occ_q != EMPTY);
    assign accept    = in_valid && in_ready;
    // Illegal words are still consumed; they just never enter the FIFO.
    assign push      = accept && keep;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    ent0_d = dec;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ent0_d = dec;
                end else if (push) begin
                    ent1_d = dec;
                    occ_d  = TWO;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    ent0_d = ent1_q;
                    occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= EMPTY;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    rec_t head;
    assign head = rst ? '0 : ent0_q;

    assign out_alu_op   = head.alu_op;
    assign out_rs1      = head.rs1;
    assign out_rs2      = head.rs2;
    assign out_rd       = head.rd;
    assign out_imm      = head.imm;
    assign out_b_is_imm = head.b_is_imm;
`ifdef ALU_DEC_ILLEGAL_EN
    assign out_illegal  = head.illegal;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: vector table, corner sequences and random traffic
// checked against a queue-based reference model of alu_op_decoder.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_op;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_b_is_imm;
`ifdef ALU_DEC_ILLEGAL_EN
    logic        out_illegal;
`endif

    always #5 clk = ~clk;

    alu_op_decoder dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_alu_op(out_alu_op),
        .out_rs1(out_rs1),
        .out_rs2(out_rs2),
        .out_rd(out_rd),
        .out_imm(out_imm),
        .out_b_is_imm(out_b_is_imm)
`ifdef ALU_DEC_ILLEGAL_EN
        ,
        .out_illegal(out_illegal)
`endif
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        b;
        logic        ill;
    } rec_t;

    typedef struct {
        logic [31:0] ins;
        bit          legal;
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        b;
    } vec_t;

`ifdef ALU_DEC_ILLEGAL_EN
    localparam bit KEEP_ILL = 1'b1;
`else
    localparam bit KEEP_ILL = 1'b0;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t q[$];
    logic [4:0] base_tbl [0:7];
    vec_t tv [0:11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_dec(input logic [31:0] w, output rec_t r);
        int  opc = int'(w[6:0]);
        int  f3  = int'(w[14:12]);
        int  f7  = int'(w[31:25]);
        bit  ok  = 1'b0;
        r = '0;
        if (opc == 'h33) begin
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            r.op = (f7 == 32) ? ((f3 == 0) ? 5'b01010 : 5'b01011)
                              : base_tbl[f3];
            r.rs1 = w[19:15];
            r.rs2 = w[24:20];
            r.rd  = w[11:7];
        end else if (opc == 'h13) begin
            if (f3 == 1 || f3 == 5) begin
                ok = (f7 == 0) || (f7 == 32 && f3 == 5);
                r.imm = 32'(w[24:20]);
            end else begin
                ok = 1'b1;
                r.imm = 32'($signed(w[31:20]));
            end
            r.op  = (f3 == 5 && f7 == 32) ? 5'b01011 : base_tbl[f3];
            r.rs1 = w[19:15];
            r.rd  = w[11:7];
            r.b   = 1'b1;
        end else if (opc == 'h37) begin
            ok    = 1'b1;
            r.rd  = w[11:7];
            r.imm = {w[31:12], 12'h000};
            r.b   = 1'b1;
        end
        if (!ok) begin
            r = '0;
            r.ill = 1'b1;
        end
        return ok;
    endfunction

    task automatic compare_all();
        bit ev;
        rec_t h;
        ev = !rst && q.size() > 0;
        chk("in_ready", 32'(in_ready), 32'(!rst && q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(ev));
        h = '0;
        if (ev) h = q[0];
        if (ev || rst) begin
            chk("alu_op", 32'(out_alu_op), 32'(h.op));
            chk("rs1", 32'(out_rs1), 32'(h.rs1));
            chk("rs2", 32'(out_rs2), 32'(h.rs2));
            chk("rd", 32'(out_rd), 32'(h.rd));
            chk("imm", out_imm, h.imm);
            chk("b_is_imm", 32'(out_b_is_imm), 32'(h.b));
`ifdef ALU_DEC_ILLEGAL_EN
            chk("illegal", 32'(out_illegal), 32'(h.ill));
`endif
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic ordy, input logic r);
        rec_t rec;
        bit   ok;
        int   sz;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        rst       = r;
        if (r) begin
            q.delete();
        end else begin
            sz = q.size();
            ok = ref_dec(ins, rec);
            if (sz > 0 && ordy) void'(q.pop_front());
            if (v && sz < 2 && (ok || KEEP_ILL)) q.push_back(rec);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int k;
        int p;
        w = $urandom;
        k = $urandom_range(0, 5);
        p = $urandom_range(0, 3);
        case (k)
            0, 5: begin
                w[6:0] = 7'h33;
                if (p < 2) w[31:25] = 7'h00;
                else if (p == 2) w[31:25] = 7'h20;
            end
            1: w[6:0] = 7'h13;
            2: begin
                w[6:0] = 7'h13;
                w[12]  = 1'b1;
                w[13]  = 1'b0;
                if (p < 2) w[31:25] = 7'h00;
                else if (p == 2) w[31:25] = 7'h20;
            end
            3: w[6:0] = 7'h37;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        base_tbl[0] = 5'b00000;
        base_tbl[1] = 5'b00001;
        base_tbl[2] = 5'b01100;
        base_tbl[3] = 5'b01110;
        base_tbl[4] = 5'b00100;
        base_tbl[5] = 5'b00101;
        base_tbl[6] = 5'b00110;
        base_tbl[7] = 5'b00111;

        tv[0]  = '{32'h002081B3, 1, 5'b00000, 1, 2, 3, 32'h0, 0};
        tv[1]  = '{32'h402081B3, 1, 5'b01010, 1, 2, 3, 32'h0, 0};
        tv[2]  = '{32'hFFF00293, 1, 5'b00000, 0, 0, 5, 32'hFFFFFFFF, 1};
        tv[3]  = '{32'h4033D313, 1, 5'b01011, 7, 0, 6, 32'h3, 1};
        tv[4]  = '{32'h4020C1B3, 0, 5'b0, 0, 0, 0, 32'h0, 0};
        tv[5]  = '{32'h00000000, 0, 5'b0, 0, 0, 0, 32'h0, 0};
        tv[6]  = '{32'h12345537, 1, 5'b00000, 0, 0, 10, 32'h12345000, 1};
        tv[7]  = '{32'h0062F233, 1, 5'b00111, 5, 6, 4, 32'h0, 0};
        tv[8]  = '{32'h80013093, 1, 5'b01110, 2, 0, 1, 32'hFFFFF800, 1};
        tv[9]  = '{32'h40209093, 0, 5'b0, 0, 0, 0, 32'h0, 0};
        tv[10] = '{32'h009453B3, 1, 5'b00101, 8, 9, 7, 32'h0, 0};
        tv[11] = '{32'h7FF1A113, 1, 5'b01100, 3, 0, 2, 32'h7FF, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        out_ready = 1'b0;
        @(negedge clk);
        step(1, 32'h002081B3, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            step(1, tv[i].ins, 1, 0);
            chk("tv_valid", 32'(out_valid), 32'(tv[i].legal || KEEP_ILL));
            if (tv[i].legal) begin
                chk("tv_op", 32'(out_alu_op), 32'(tv[i].op));
                chk("tv_rs1", 32'(out_rs1), 32'(tv[i].rs1));
                chk("tv_rs2", 32'(out_rs2), 32'(tv[i].rs2));
                chk("tv_rd", 32'(out_rd), 32'(tv[i].rd));
                chk("tv_imm", out_imm, tv[i].imm);
                chk("tv_b", 32'(out_b_is_imm), 32'(tv[i].b));
            end
`ifdef ALU_DEC_ILLEGAL_EN
            chk("tv_ill", 32'(out_illegal), 32'(!tv[i].legal));
            if (!tv[i].legal) chk("tv_ill_op", 32'(out_alu_op), 32'd0);
`endif
            step(0, 0, 1, 0);
            chk("tv_drain", 32'(out_valid), 32'd0);
        end

        step(1, 32'h002081B3, 0, 0);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        step(1, 32'h0062F233, 0, 0);
        chk("bp_ready2", 32'(in_ready), 32'd0);
        step(1, 32'h7FF1A113, 0, 0);
        chk("bp_ready3", 32'(in_ready), 32'd0);
        chk("bp_head_a", 32'(out_rd), 32'd3);
        step(1, 32'h7FF1A113, 1, 0);
        chk("bp_head_b", 32'(out_rd), 32'd4);
        step(1, 32'h7FF1A113, 1, 0);
        chk("bp_head_c", 32'(out_rd), 32'd2);
        chk("bp_head_c_imm", out_imm, 32'h7FF);
        step(0, 0, 1, 0);
        chk("bp_empty", 32'(out_valid), 32'd0);

        step(1, 32'h002081B3, 0, 0);
        step(1, 32'h402081B3, 0, 0);
        step(0, 0, 1, 1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        step(0, 0, 1, 0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_instr(),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_instr holds an instruction.
REQ-005 in_ready  output  1  decoder can accept an instruction this cycle.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  decoded record present on out_* ports.
REQ-008 out_ready  input  1  consumer (ALU stage) takes the record this cycle.
REQ-009 out_alu_op  output  5  ALU op code: ADD 00000, SUB 01010, AND 00111, OR 00110, XOR 00100, SLT 01100, SLTU 01110, SLL 00001, SRL 00101, SRA 01011.
REQ-010 out_rs1 / out_rs2 / out_rd  output  5 each  register indices.
REQ-011 out_imm  output  32  operand-B immediate; 0 when out_b_is_imm=0.
REQ-012 out_b_is_imm  output  1  ALU operand B comes from out_imm, not rs2.
REQ-013 out_illegal  output  1  present only when ALU_DEC_ILLEGAL_EN is defined.

Function
REQ-014 Transfer occurs on a rising edge with valid&ready on that side; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-015 Decoding SHALL occur at input; decoded records SHALL be held in a 2-entry FIFO (skid buffer) with occupancy states EMPTY, ONE and TWO.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO, driven from the head entry; latency from input accept to out_valid SHALL be exactly 1 cycle.
REQ-018 Transitions: accept only -> +1; output transfer only -> -1; both in the same cycle -> occupancy unchanged and order preserved.
REQ-019 Records SHALL be emitted in strict acceptance order with no drop or duplication, except as stated in REQ-026.
REQ-020 For OP (opcode 0110011), funct3 selects the op: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-021 For OP, funct7=0100000 SHALL be legal only with funct3 000 (SUB) or 101 (SRA); otherwise funct7 SHALL be 0000000. Output fields: b_is_imm=0, imm=0.
REQ-022 For OP-IMM (opcode 0010011), funct3 mapping SHALL be as REQ-020 with no SUB; imm = sign-extend(instr[31:20]); b_is_imm=1; rs2=0.
REQ-023 OP-IMM shifts (funct3 001/101): imm = {27'b0, instr[24:20]}; instr[31:25] SHALL be 0000000, or 0100000 for SRAI only.
REQ-024 For LUI (opcode 0110111): alu_op=ADD, rs1=0, rs2=0, imm={instr[31:12],12'b0}, b_is_imm=1.
REQ-025 Any other opcode, or a funct7 violation, SHALL be illegal.
REQ-026 Without the macro, an illegal instruction SHALL be accepted and discarded; it SHALL never produce out_valid.

Reset
REQ-027 While rst=1, occupancy SHALL be EMPTY, out_valid=0, in_ready=0, and all out_* data outputs SHALL be 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset mid-operation SHALL discard all buffered records; no record accepted before reset SHALL appear afterwards.

Configuration
REQ-030 The macro is ALU_DEC_ILLEGAL_EN.
REQ-031 With ALU_DEC_ILLEGAL_EN defined: out_illegal port exists; illegal instructions SHALL be emitted as records with out_illegal=1, alu_op=ADD, rd=0, rs1=0, rs2=0, imm=0, b_is_imm=0; legal records SHALL carry out_illegal=0.
REQ-032 With ALU_DEC_ILLEGAL_EN undefined: no out_illegal port; REQ-026 applies.

Verification
REQ-033 in_instr=0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_op=00000, rs1=1, rs2=2, rd=3, b_is_imm=0, imm=0.
REQ-034 0x402081B3 -> alu_op=01010; 0xFFF00293 (addi x5,x0,-1) -> alu_op=00000, rd=5, imm=0xFFFFFFFF, b_is_imm=1.
REQ-035 0x4033D313 (srai x6,x7,3) -> alu_op=01011, rs1=7, rd=6, imm=0x00000003; 0x4020C1B3 (funct7 0100000 with XOR) -> illegal.
REQ-036 out_ready=0, present three legal instructions back-to-back -> two accepted, in_ready=0 on the third; raise out_ready -> all three emitted in order, one per cycle.
REQ-037 0x00000000 -> macro undefined: accepted, no out_valid; macro defined: record with out_illegal=1, alu_op=00000.
REQ-038 Occupancy TWO, assert rst for 1 cycle -> out_valid=0 in the next cycle, in_ready=1 in the following cycle, no stale records emitted.
